// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer control/datapath bundle
interface fetch_sequencer_if #(
   parameter int PC_W  = 10,
   parameter int OFF_W = 6,
   parameter int CNT_W = 16
);
   logic             Start;
   logic             Branch;
   logic             Taken;
   logic [OFF_W-1:0] Offset;
   logic             Stall;
   logic [PC_W-1:0]  ProgLen;
   logic [PC_W-1:0]  PC;
   logic             Run;
   logic             Ack;
   logic [CNT_W-1:0] Retired;

   modport master (
      output Start, Branch, Taken, Offset, Stall, ProgLen,
      input  PC, Run, Ack, Retired
   );

   modport slave (
      input  Start, Branch, Taken, Offset, Stall, ProgLen,
      output PC, Run, Ack, Retired
   );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, next-PC select and start/run/done control
module fetch_sequencer #(
   parameter int PC_W  = 10,
   parameter int OFF_W = 6,
   parameter int CNT_W = 16
) (
   input logic Clk,
   input logic Reset,
   fetch_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0]  offset_ext;
   logic [PC_W-1:0]  target;

   assign offset_ext = {{(PC_W-OFF_W){bus.Offset[OFF_W-1]}}, bus.Offset};

   // Modulo arithmetic lets a backward wrap below 0 land above ProgLen and end the program
   always_comb begin
      target = pc_q + PC_W'(1);
      if (bus.Branch && bus.Taken)
         target = pc_q + offset_ext;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            pc_d  = '0;
            cnt_d = '0;
            if (bus.Start)
               state_d = RUN;
         end
         RUN: begin
            if (!bus.Stall) begin
               if (cnt_q != {CNT_W{1'b1}})
                  cnt_d = cnt_q + CNT_W'(1);
               if (target < bus.ProgLen)
                  pc_d = target;
               else
                  state_d = DONE;
            end
         end
         DONE: begin
            if (bus.Start) begin
               state_d = RUN;
               pc_d    = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.PC      = pc_q;
   assign bus.Run     = (state_q == RUN);
   assign bus.Ack     = (state_q == DONE);
   assign bus.Retired = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
   logic Clk = 1'b0;
   logic Reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 Clk = ~Clk;

   fetch_sequencer_if #(.PC_W(10), .OFF_W(6), .CNT_W(16)) m ();
   fetch_sequencer_if #(.PC_W(10), .OFF_W(6), .CNT_W(4))  s ();

   fetch_sequencer #(.PC_W(10), .OFF_W(6), .CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .bus(m.slave)
   );

   // Narrow counter copy for the saturation case
   fetch_sequencer #(.PC_W(10), .OFF_W(6), .CNT_W(4)) dut_sat (
      .Clk(Clk), .Reset(Reset), .bus(s.slave)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_at(input int p);
      m.Branch = 1'b0; m.Taken = 1'b0; m.Offset = '0; m.Stall = 1'b0;
      Reset = 1'b1; m.Start = 1'b0;
      tick();
      Reset = 1'b0; m.Start = 1'b1;
      tick();
      m.Start = 1'b0;
      repeat (p) tick();
   endtask

   initial begin
      Reset = 1'b1;
      m.Start = 1'b0; m.Branch = 1'b0; m.Taken = 1'b0; m.Offset = '0;
      m.Stall = 1'b0; m.ProgLen = 10'd5;
      s.Start = 1'b0; s.Branch = 1'b0; s.Taken = 1'b0; s.Offset = '0;
      s.Stall = 1'b0; s.ProgLen = 10'd4;
      tick();
      check("rst_pc", int'(m.PC), 0);
      check("rst_run", int'(m.Run), 0);
      check("rst_ack", int'(m.Ack), 0);
      check("rst_ret", int'(m.Retired), 0);

      // Straight-line program of 5
      Reset = 1'b0; m.Start = 1'b1;
      tick();
      m.Start = 1'b0;
      check("sl_run", int'(m.Run), 1);
      check("sl_pc0", int'(m.PC), 0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("sl_pc", int'(m.PC), i);
         check("sl_ret", int'(m.Retired), i);
      end
      tick();
      check("sl_ack", int'(m.Ack), 1);
      check("sl_run_lo", int'(m.Run), 0);
      check("sl_pc_hold", int'(m.PC), 4);
      check("sl_ret5", int'(m.Retired), 5);
      tick();
      check("done_frozen_pc", int'(m.PC), 4);
      check("done_frozen_ret", int'(m.Retired), 5);

      // Restart from DONE
      m.Start = 1'b1;
      tick();
      m.Start = 1'b0;
      check("rs_run", int'(m.Run), 1);
      check("rs_pc", int'(m.PC), 0);
      check("rs_ret", int'(m.Retired), 0);

      m.ProgLen = 10'd10;
      start_at(2);
      m.Branch = 1'b1; m.Taken = 1'b1; m.Offset = 6'b000011;
      tick();
      check("br_fwd", int'(m.PC), 5);

      start_at(2);
      m.Branch = 1'b1; m.Taken = 1'b0; m.Offset = 6'b000011;
      tick();
      check("br_nt", int'(m.PC), 3);

      start_at(2);
      m.Branch = 1'b0; m.Taken = 1'b1; m.Offset = 6'b000011;
      tick();
      check("br_none", int'(m.PC), 3);

      start_at(6);
      m.Branch = 1'b1; m.Taken = 1'b1; m.Offset = 6'b111100;
      tick();
      check("br_back", int'(m.PC), 2);
      check("br_back_ret", int'(m.Retired), 7);

      start_at(3);
      m.Start = 1'b1;
      tick();
      m.Start = 1'b0;
      check("start_ign", int'(m.PC), 4);

      // Out-of-range targets
      m.ProgLen = 10'd8;
      start_at(1);
      m.Branch = 1'b1; m.Taken = 1'b1; m.Offset = 6'b111110;
      tick();
      check("oor_wrap_ack", int'(m.Ack), 1);
      check("oor_wrap_pc", int'(m.PC), 1);
      check("oor_wrap_ret", int'(m.Retired), 2);

      start_at(3);
      m.Branch = 1'b1; m.Taken = 1'b1; m.Offset = 6'd5;
      tick();
      check("oor_fwd_ack", int'(m.Ack), 1);
      check("oor_fwd_pc", int'(m.PC), 3);

      start_at(3);
      m.Branch = 1'b1; m.Taken = 1'b1; m.Offset = 6'd4;
      tick();
      check("edge_in_pc", int'(m.PC), 7);
      check("edge_in_run", int'(m.Run), 1);

      // Reset dominance mid-program
      m.ProgLen = 10'd10;
      start_at(7);
      check("pre_rst_pc", int'(m.PC), 7);
      Reset = 1'b1; m.Start = 1'b1;
      tick();
      check("rd_pc", int'(m.PC), 0);
      check("rd_run", int'(m.Run), 0);
      check("rd_ack", int'(m.Ack), 0);
      check("rd_ret", int'(m.Retired), 0);
      Reset = 1'b0; m.Start = 1'b0;

      // Stall with a taken branch presented
      start_at(4);
      m.Branch = 1'b1; m.Taken = 1'b1; m.Offset = 6'd3; m.Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("st_pc", int'(m.PC), 4);
         check("st_ret", int'(m.Retired), 4);
      end
      m.Stall = 1'b0;
      tick();
      check("st_rel_pc", int'(m.PC), 7);
      check("st_rel_ret", int'(m.Retired), 5);

      // Stall on the last instruction delays DONE
      m.ProgLen = 10'd5;
      start_at(4);
      m.Stall = 1'b1;
      tick();
      check("st_last_ack", int'(m.Ack), 0);
      check("st_last_pc", int'(m.PC), 4);
      m.Stall = 1'b0;
      tick();
      check("st_last_ack1", int'(m.Ack), 1);
      check("st_last_ret", int'(m.Retired), 5);

      // Saturation on the 4-bit counter with a self-loop
      Reset = 1'b1;
      tick();
      Reset = 1'b0; s.Start = 1'b1;
      tick();
      s.Start = 1'b0;
      s.Branch = 1'b1; s.Taken = 1'b1; s.Offset = '0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         check("sat_pc", int'(s.PC), 0);
         check("sat_ret", int'(s.Retired), (i < 15) ? i : 15);
      end
      check("sat_run", int'(s.Run), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
